// File: rtl/leiwand_rv32_mem_if.sv
`default_nettype none
// ============================================================================
// Module   : leiwand_rv32_mem_if
// Brief    : Single-beat load/store bus master between the rv32 memory stage
//            and the on-chip RAM (cyc/stb/stall/ack handshake).
// Revision : 1.0 - initial release
// ============================================================================

module leiwand_rv32_mem_if #(
    parameter int MEM_WIDTH      = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_req,
    input  logic                 i_we,
    input  logic [MEM_WIDTH-1:0] i_addr,
    input  logic [MEM_WIDTH-1:0] i_wdat,
    input  logic [2:0]           i_size,
    input  logic                 i_unsigned,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_err,
    output logic [MEM_WIDTH-1:0] o_rdat,
    output logic                 o_cyc,
    output logic                 o_stb,
    output logic                 o_we,
    output logic [MEM_WIDTH-1:0] o_adr,
    output logic [MEM_WIDTH-1:0] o_dat,
    output logic [2:0]           o_size,
    input  logic                 i_stall,
    input  logic                 i_ack,
    input  logic [MEM_WIDTH-1:0] i_dat
);

    localparam int               c_cnt_w    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ARB  = 3'd1,
        ST_STB  = 3'd2,
        ST_WAIT = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [c_cnt_w-1:0]   r_cnt;
    logic                 r_err;
    logic                 w_err_next;
    logic                 r_we;
    logic                 r_unsigned;
    logic [MEM_WIDTH-1:0] r_adr;
    logic [MEM_WIDTH-1:0] r_dat;
    logic [2:0]           r_size;
    logic [MEM_WIDTH-1:0] r_rdat;

    logic                 w_req_ok;
    logic                 w_bus;
    logic                 w_cnt_last;
    logic [7:0]           w_byte;
    logic [15:0]          w_half;
    logic [MEM_WIDTH-1:0] w_load;

    // Size must be 1/2/4 and the address naturally aligned to it.
    assign w_req_ok = (i_size == 3'd1) ||
                      ((i_size == 3'd2) && !i_addr[0]) ||
                      ((i_size == 3'd4) && (i_addr[1:0] == 2'd0));

    assign w_bus      = (r_state == ST_ARB) || (r_state == ST_STB) || (r_state == ST_WAIT);
    assign w_cnt_last = (r_cnt == c_cnt_last);

    always_comb begin
        w_next     = r_state;
        w_err_next = r_err;
        case (r_state)
            ST_IDLE: begin
                if (i_req) begin
                    if (w_req_ok) begin
                        w_next     = ST_ARB;
                        w_err_next = 1'b0;
                    end else begin
                        w_next     = ST_DONE;
                        w_err_next = 1'b1;
                    end
                end
            end
            ST_ARB: begin
                if (w_cnt_last) begin
                    w_next     = ST_DONE;
                    w_err_next = 1'b1;
                end else if (!i_stall) begin
                    w_next = ST_STB;
                end
            end
            ST_STB: begin
                if (w_cnt_last) begin
                    w_next     = ST_DONE;
                    w_err_next = 1'b1;
                end else begin
                    w_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // An ack on the final allowed cycle still completes cleanly.
                if (i_ack) begin
                    w_next     = ST_DONE;
                    w_err_next = 1'b0;
                end else if (w_cnt_last) begin
                    w_next     = ST_DONE;
                    w_err_next = 1'b1;
                end
            end
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_byte = i_dat[7:0];
        case (r_adr[1:0])
            2'd1:    w_byte = i_dat[15:8];
            2'd2:    w_byte = i_dat[23:16];
            2'd3:    w_byte = i_dat[31:24];
            default: w_byte = i_dat[7:0];
        endcase
        w_half = r_adr[1] ? i_dat[31:16] : i_dat[15:0];
        case (r_size)
            3'd1:    w_load = {{(MEM_WIDTH-8){w_byte[7] & ~r_unsigned}}, w_byte};
            3'd2:    w_load = {{(MEM_WIDTH-16){w_half[15] & ~r_unsigned}}, w_half};
            default: w_load = i_dat;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt      <= '0;
            r_err      <= 1'b0;
            r_we       <= 1'b0;
            r_unsigned <= 1'b0;
            r_adr      <= '0;
            r_dat      <= '0;
            r_size     <= '0;
            r_rdat     <= '0;
        end else begin
            r_err <= w_err_next;
            if (r_state == ST_IDLE) begin
                r_cnt <= '0;
            end else if (w_bus) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if ((r_state == ST_IDLE) && i_req) begin
                r_we       <= i_we;
                r_unsigned <= i_unsigned;
                r_adr      <= i_addr;
                r_dat      <= i_wdat;
                r_size     <= i_size;
            end
            if ((r_state == ST_WAIT) && i_ack && !r_we) begin
                r_rdat <= w_load;
            end
        end
    end

    assign o_busy = (r_state != ST_IDLE);
    assign o_done = (r_state == ST_DONE);
    assign o_err  = (r_state == ST_DONE) && r_err;
    assign o_rdat = r_rdat;
    assign o_cyc  = w_bus;
    assign o_stb  = (r_state == ST_STB);
    assign o_we   = r_we;
    assign o_adr  = r_adr;
    assign o_dat  = r_dat;
    assign o_size = r_size;

endmodule

`default_nettype wire
